char_motion_ctrl: RTL

Player movement controller for the overworld. Converts held keyboard keycodes into the per-frame movement controls consumed directly downstream by the frame drawer: `direction`, `charIsMoving`, `charIsRunning` and `charMoveFrame`. It paces each 16-pixel tile step in whole video frames, consults the gym bounds checker before committing a step, and chains consecutive steps while a key is held.

---
 rtl/overworld_pkg.sv | 30 +++
 rtl/vs_tick_gen.sv | 27 ++
 rtl/char_motion_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/overworld_pkg.sv
// rtl/overworld_pkg.sv - shared overworld types, keycodes and game-state constants
package overworld_pkg;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        STEP = 2'd2
    } motion_state_t;

    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_B = 8'h05;

    localparam logic [3:0] GAME_STATE_MAIN = 4'd3;

    // Walk cycle: left foot, stand, right foot, stand.
    function automatic logic [1:0] quarter_frame(input logic [1:0] q);
        return (q == 2'd3) ? 2'd1 : q;
    endfunction

endpackage

// File: rtl/vs_tick_gen.sv
// rtl/vs_tick_gen.sv - VGA_VS synchroniser and rising-edge frame tick
module vs_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic VGA_VS,
    output logic tick
);

    logic vs_meta;
    logic vs_sync;
    logic vs_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vs_meta <= VGA_VS;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            tick    <= vs_sync & ~vs_prev;
        end
    end

endmodule

// File: rtl/char_motion_ctrl.sv
// rtl/char_motion_ctrl.sv - keycode-driven tile-step movement controller for the overworld
module char_motion_ctrl
    import overworld_pkg::*;
#(
    parameter int WALK_TICKS = 32,
    parameter int RUN_TICKS  = 16,
    parameter int TURN_TICKS = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VGA_VS,
    input  logic [3:0] state_num,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic       atBounds,
    output logic [1:0] probe_dir,
    output logic [1:0] direction,
    output logic       charIsMoving,
    output logic       charIsRunning,
    output logic [1:0] charMoveFrame,
    output logic       step_done
);

    localparam logic [5:0] WALK_LEN = 6'(WALK_TICKS);
    localparam logic [5:0] RUN_LEN  = 6'(RUN_TICKS);
    localparam logic [5:0] TURN_LEN = 6'(TURN_TICKS);

    logic tick;

    vs_tick_gen u_vs_tick_gen (
        .Clk    (Clk),
        .Reset  (Reset),
        .VGA_VS (VGA_VS),
        .tick   (tick)
    );

    logic key_dn, key_up, key_lf, key_rt, key_run, any_dir, can_step;

    assign key_dn  = (keycode0 == KEY_S) || (keycode1 == KEY_S);
    assign key_up  = (keycode0 == KEY_W) || (keycode1 == KEY_W);
    assign key_lf  = (keycode0 == KEY_A) || (keycode1 == KEY_A);
    assign key_rt  = (keycode0 == KEY_D) || (keycode1 == KEY_D);
    assign key_run = (keycode0 == KEY_B) || (keycode1 == KEY_B);
    assign any_dir = key_dn | key_up | key_lf | key_rt;

    // Lowest priority first so the highest-priority key wins.
    always_comb begin
        probe_dir = direction;
        if (key_rt) probe_dir = RIGHT;
        if (key_lf) probe_dir = LEFT;
        if (key_up) probe_dir = UP;
        if (key_dn) probe_dir = DOWN;
    end

    assign can_step = any_dir && (probe_dir == direction) && !atBounds;

    motion_state_t state, nxt_state;
    logic [5:0] cnt, nxt_cnt, nxt_len, nxt_elapsed;
    logic [1:0] nxt_dir, nxt_frame, quarter;
    logic       nxt_run, nxt_done;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_dir   = direction;
        nxt_run   = charIsRunning;
        nxt_done  = 1'b0;
        if (state_num != GAME_STATE_MAIN) begin
            nxt_state = IDLE;
            nxt_cnt   = 6'd0;
            nxt_run   = 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (any_dir && (probe_dir != direction)) begin
                        nxt_dir   = probe_dir;
                        nxt_cnt   = TURN_LEN;
                        nxt_state = TURN;
                    end else if (can_step) begin
                        nxt_run   = key_run;
                        nxt_cnt   = key_run ? RUN_LEN : WALK_LEN;
                        nxt_state = STEP;
                    end
                end
                TURN: begin
                    if (cnt <= 6'd1) begin
                        nxt_cnt   = 6'd0;
                        nxt_state = IDLE;
                    end else begin
                        nxt_cnt = cnt - 6'd1;
                    end
                end
                STEP: begin
                    if (cnt <= 6'd1) begin
                        nxt_done = 1'b1;
                        if (can_step) begin
                            nxt_run = key_run;
                            nxt_cnt = key_run ? RUN_LEN : WALK_LEN;
                        end else begin
                            nxt_run   = 1'b0;
                            nxt_cnt   = 6'd0;
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_cnt = cnt - 6'd1;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_cnt   = 6'd0;
                end
            endcase
        end
    end

    // Animation column is derived from ticks elapsed since the step was loaded.
    always_comb begin
        nxt_len     = nxt_run ? RUN_LEN : WALK_LEN;
        nxt_elapsed = nxt_len - nxt_cnt;
        quarter     = 2'(nxt_elapsed >> (nxt_run ? 3'd2 : 3'd3));
        nxt_frame   = (nxt_state == STEP) ? quarter_frame(quarter) : 2'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= 6'd0;
            direction     <= 2'd0;
            charIsMoving  <= 1'b0;
            charIsRunning <= 1'b0;
            charMoveFrame <= 2'd1;
            step_done     <= 1'b0;
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            direction     <= nxt_dir;
            charIsMoving  <= (nxt_state == STEP);
            charIsRunning <= nxt_run;
            charMoveFrame <= nxt_frame;
            step_done     <= nxt_done;
        end
    end

endmodule
